inst_fetch_queue: RTL
=====================

// Module: inst_fetch_queue
// PURPOSE
//  Fetch front end, directly upstream of the datapath. Issues in-order word reads to an
//  instruction memory port with a req/gnt + rvalid handshake and buffers the returned words
//  in a DEPTH-entry queue. Presents {inst, inst_pc} to the datapath with a valid/ready
//  handshake. A redirect from branch/jump resolution flushes the queue and discards
//  responses that are still in flight.
// PARAMETERS
//  DEPTH     4          queue entries; also max (queued + outstanding) requests; power of 2, >=2
//  XLEN      32         address/instruction width
//  RESET_PC  32'h0      fetch address after reset
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous reset, active-low (0 = reset)
//  mem_req      out  1     read request; mem_addr valid while high
//  mem_addr     out  XLEN  word-aligned fetch address
//  mem_gnt      in   1     request accepted this cycle when mem_req & mem_gnt
//  mem_rvalid   in   1     read data valid; responses return in grant order, >=1 cycle after gnt
//  mem_rdata    in   XLEN  read data
//  redirect     in   1     flush and restart fetch at redirect_pc
//  redirect_pc  in   XLEN  new fetch address
//  inst_valid   out  1     queue head valid
//  inst_ready   in   1     datapath consumes head when inst_valid & inst_ready
//  inst         out  XLEN  head instruction
//  inst_pc      out  XLEN  head instruction address
//  inst_fault   out  1     head is a misaligned-fetch fault entry (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0): fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0; mem_req=0,
//   inst_valid=0, inst_fault=0, inst=0, inst_pc=0. Takes effect asynchronously.
//  Credit: mem_req = !redirect & (count + outstanding < DEPTH) & !halted. mem_addr=fetch_pc.
//   A grant sets fetch_pc += 4 (modulo 2^XLEN, wraps silently) and outstanding += 1.
//  Response: mem_rvalid decrements outstanding. If drop_cnt != 0, the word is discarded and
//   drop_cnt -= 1; otherwise it is pushed with its pc (tracked resp_pc, +4 per push).
//   Grant and rvalid in the same cycle: outstanding unchanged.
//  Output: head registered; no rvalid->inst_valid bypass. rvalid in cycle N -> inst_valid
//   earliest in cycle N+1. Push and pop in the same cycle are legal with the queue full.
//   Overflow cannot occur by construction; an rvalid with outstanding==0 is illegal
//   (assertion).
//  Redirect (cycle R, highest priority): inst_valid forced 0 and no pop in R; mem_req=0;
//   any rvalid in R is dropped. At R+1: queue empty, fetch_pc=resp_pc=redirect_pc,
//   drop_cnt = outstanding remaining after R. Back-to-back redirects: the last one wins.
//   drop_cnt accumulates correctly.
//  Latency: memory with gnt=1 and rvalid 1 cycle after gnt -> redirect at R gives
//   req/gnt at R+1, rvalid at R+2, inst_valid at R+3.
//  Steady state with inst_ready=1 and a 1-cycle memory: one instruction per cycle.
//  No internal FSM beyond the halted flag. Counters are clog2(DEPTH+1) bits wide.
// CONFIGURATION
//  FETCH_MISALIGN_EN defined: redirect_pc[1:0]!=0 sets halted. Halted means no requests,
//   pending responses still dropped, and one entry {inst=`NOP_INST, inst_pc=redirect_pc,
//   inst_fault=1} is pushed. Halted clears only on the next redirect.
//  Not defined: redirect_pc[1:0] is ignored (treated as 00), halted never set,
//   inst_fault tied 0.
// STRUCTURE
//  defines.v: `NOP_INST (32'h00000013), `FETCH_STEP (4). These are shared with the datapath
//   and imm_gen.
//  Sub-module fetch_fifo: a synchronous FIFO with flush, async active-low reset,
//   {fault,pc,inst} payload, count output. The top level holds the credit, drop and PC logic.
// TESTING
//  1 Reset: rst=0 with traffic active -> all outputs 0 immediately; after release the first
//    mem_addr=RESET_PC.
//  2 Stream, gnt=1, 1-cycle rvalid, ready=1 -> inst_pc 0,4,8,... one per cycle, data matches.
//  3 ready=0 -> exactly 4 grants, mem_req drops, 4 entries queued. ready=1 -> drains in order
//    and requests resume.
//  4 3 requests in flight, redirect to 0x100 -> 3 rvalids dropped, first inst_pc=0x100,
//    then 0x104.
//  5 Same cycle: redirect, rvalid, ready=1 with a valid head -> no pop, word dropped,
//    queue empty at R+1.
//  6 (FETCH_MISALIGN_EN) redirect to 0x102 -> one fault entry (pc=0x102, NOP), no mem_req
//    until a redirect to 0x200.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue and the datapath.
// Holds the NOP encoding and fetch step, plus the counter-width helper.
`ifndef NOP_INST
`define NOP_INST 32'h00000013
`endif
`ifndef FETCH_STEP
`define FETCH_STEP 4
`endif

package inst_fetch_queue_pkg;

  localparam logic [31:0] NOP_INST   = `NOP_INST;
  localparam int          FETCH_STEP = `FETCH_STEP;

  // Width needed to hold values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Synchronous FIFO with flush for the fetch queue; payload is {fault, pc, inst}.
// Storage is not reset; the head is only meaningful while count is nonzero.
module inst_fetch_queue_fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 65,
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          head_valid,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop     = pop && (count != '0);
  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      // Simultaneous push and pop is legal even when full.
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: credit-limited in-order memory reads into a queue, with redirect flush.
// FETCH_MISALIGN_EN enables a fault entry and fetch halt on a misaligned redirect target.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  localparam int CW = cnt_width(DEPTH);
  localparam int W  = 2 * XLEN + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] new_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            grant;
  logic            push_resp;
  logic            fault_push;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_valid;
  logic            halted;
  logic            fault_pend;
  logic [W-1:0]    push_data;
  logic [W-1:0]    head_data;

`ifdef FETCH_MISALIGN_EN
  logic misalign;

  assign misalign = (redirect_pc[1:0] != 2'b00);
  assign new_pc   = redirect_pc;

  // Halt persists until the next redirect; the fault entry is pushed once, right after the flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted     <= 1'b0;
      fault_pend <= 1'b0;
    end else if (redirect) begin
      halted     <= misalign;
      fault_pend <= misalign;
    end else if (fault_pend) begin
      fault_pend <= 1'b0;
    end
  end
`else
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign new_pc        = {redirect_pc[XLEN-1:2], 2'b00};
  assign halted        = 1'b0;
  assign fault_pend    = 1'b0;
`endif

  // Credit covers both queued entries and reads still in flight, so the queue never overflows.
  assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign mem_req     = rst && !redirect && !halted && (credit_used < (CW+1)'(DEPTH));
  assign mem_addr    = fetch_pc;
  assign grant       = mem_req && mem_gnt;

  assign push_resp  = mem_rvalid && !redirect && !halted && (drop_cnt == '0);
  assign fault_push = fault_pend && !redirect;
  assign fifo_push  = push_resp || fault_push;
  assign push_data  = fault_push ? {1'b1, fetch_pc, XLEN'(NOP_INST)}
                                 : {1'b0, resp_pc, mem_rdata};

  assign inst_valid = fifo_valid && !redirect;
  assign fifo_pop   = inst_valid && inst_ready;
  assign inst       = inst_valid ? head_data[XLEN-1:0]      : '0;
  assign inst_pc    = inst_valid ? head_data[2*XLEN-1:XLEN] : '0;
  assign inst_fault = inst_valid && head_data[W-1];

  always_comb begin
    outstanding_nxt = outstanding;
    case ({grant, mem_rvalid})
      2'b10:   outstanding_nxt = outstanding + CW'(1);
      2'b01:   outstanding_nxt = outstanding - CW'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect) begin
        fetch_pc <= new_pc;
        resp_pc  <= new_pc;
        // Everything still in flight after this cycle belongs to the old stream.
        drop_cnt <= outstanding_nxt;
      end else begin
        if (grant)
          fetch_pc <= fetch_pc + XLEN'(FETCH_STEP);
        if (push_resp)
          resp_pc <= resp_pc + XLEN'(FETCH_STEP);
        if (mem_rvalid && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  inst_fetch_queue_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (fifo_push),
    .push_data  (push_data),
    .pop        (fifo_pop),
    .head_data  (head_data),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst) mem_rvalid |-> (outstanding != '0)
  );

endmodule
